pattern_detect_ctrl: RTL and testbench

Controller and programmable matcher for serial bitstream pattern detection. It holds a runtime pattern/length configuration and arms and disarms detection with a start/abort handshake. It counts matches, supports overlapping and non-overlapping modes, and signals completion after a programmed number of matches. It sits between the host/config logic and the serial data source, replacing fixed-pattern detectors.

---
 rtl/pattern_detect_ctrl_pkg.sv | 16 +
 rtl/pattern_match_core.sv | 55 +++++
 rtl/pattern_detect_ctrl.sv | 141 ++++++++++++++
 tb/tb_pattern_detect_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_detect_ctrl_pkg.sv
// Shared definitions for the programmable serial pattern detector.
//   state_t     : controller state encoding (IDLE, RUN, DONE)
//   RST_PATTERN : configuration pattern loaded by reset (zero-extended 'b1011)
//   RST_LEN     : configuration length loaded by reset
package pattern_detect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] RST_PATTERN = 16'b1011;
  localparam int          RST_LEN     = 4;

endpackage

// File: rtl/pattern_match_core.sv
// Shift register, fill counter and length-masked compare for the detector.
// Ports:
//   clk        : clock, rising edge
//   shift_en   : accept d into the shift register this cycle
//   clear      : zero shift register and fill counter (reset / start)
//   clear_fill : with shift_en, zero fill instead of advancing it
//   d          : serial data bit
//   len        : active pattern length (1..MAX_LEN)
//   pattern    : pattern, bit [len-1] is the oldest bit
//   hit        : the shift register as it would be after accepting d matches
module pattern_match_core #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               shift_en,
  input  logic               clear,
  input  logic               clear_fill,
  input  logic               d,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] pattern,
  output logic               hit
);

  logic [MAX_LEN-1:0] sr_reg;
  logic [MAX_LEN-1:0] sr_next;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_reg;
  logic [LEN_W-1:0]   fill_next;

  assign sr_next   = {sr_reg[MAX_LEN-2:0], d};
  assign fill_next = (fill_reg == LEN_W'(MAX_LEN)) ? fill_reg : fill_reg + 1'b1;

  // Only the low len bits take part in the compare.
  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign mask[gi] = (32'(len) > gi);
    end
  endgenerate

  // Evaluated on the post-shift values so the controller can register the
  // match in the same edge that stores the completing bit.
  assign hit = (fill_next >= len) && (((sr_next ^ pattern) & mask) == '0);

  always_ff @(posedge clk) begin
    if (clear) begin
      sr_reg   <= '0;
      fill_reg <= '0;
    end else if (shift_en) begin
      sr_reg   <= sr_next;
      fill_reg <= clear_fill ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/pattern_detect_ctrl.sv
// Controller for runtime-programmable serial pattern detection.
// Ports:
//   clk_i, rst_i        : clock and synchronous active-high reset
//   cfg_we_i, cfg_*_i   : configuration write (accepted only in IDLE)
//   cfg_err_o           : pulse, configuration write rejected (bad length)
//   start_i, abort_i    : arm / disarm requests
//   d_valid_i, d_i      : serial bit stream
//   busy_o              : high while armed (RUN)
//   match_o             : pulse per detected match (one cycle after the bit)
//   match_cnt_o         : saturating match count since last start
//   done_o              : pulse with the match that reaches the target
module pattern_detect_ctrl
  import pattern_detect_ctrl_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_we_i,
  input  logic [MAX_LEN-1:0] cfg_pattern_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic               cfg_overlap_i,
  input  logic [CNT_W-1:0]   cfg_target_i,
  output logic               cfg_err_o,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               d_valid_i,
  input  logic               d_i,
  output logic               busy_o,
  output logic               match_o,
  output logic [CNT_W-1:0]   match_cnt_o,
  output logic               done_o
);

  state_t             state_reg, state_next;
  logic [MAX_LEN-1:0] cfg_pattern_reg;
  logic [LEN_W-1:0]   cfg_len_reg;
  logic               cfg_overlap_reg;
  logic [CNT_W-1:0]   cfg_target_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   cnt_inc;
  logic               match_reg, done_reg, err_reg;

  logic len_ok, cfg_accept, cfg_reject, start_ok;
  logic shift_en, count_en, done_hit, hit;

  assign len_ok  = (cfg_len_i != '0) && (cfg_len_i <= LEN_W'(MAX_LEN));
  assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;

  pattern_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_core (
    .clk        (clk_i),
    .shift_en   (shift_en),
    .clear      (rst_i | start_ok),
    .clear_fill (hit & ~cfg_overlap_reg),
    .d          (d_i),
    .len        (cfg_len_reg),
    .pattern    (cfg_pattern_reg),
    .hit        (hit)
  );

  always_comb begin
    state_next = state_reg;
    cfg_accept = 1'b0;
    cfg_reject = 1'b0;
    start_ok   = 1'b0;
    shift_en   = 1'b0;
    count_en   = 1'b0;
    done_hit   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cfg_we_i) begin
          cfg_accept = len_ok;
          cfg_reject = ~len_ok;
        end
        // A rejected write in the same cycle blocks the start.
        if (start_i && !cfg_reject) begin
          start_ok   = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_next = ST_IDLE;
        end else if (d_valid_i) begin
          shift_en = 1'b1;
          if (hit) begin
            count_en = 1'b1;
            if ((cfg_target_reg != '0) && (cnt_inc == cfg_target_reg)) begin
              done_hit   = 1'b1;
              state_next = ST_DONE;
            end
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg       <= ST_IDLE;
      cfg_pattern_reg <= RST_PATTERN[MAX_LEN-1:0];
      cfg_len_reg     <= LEN_W'(RST_LEN);
      cfg_overlap_reg <= 1'b1;
      cfg_target_reg  <= '0;
      cnt_reg         <= '0;
      match_reg       <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      state_reg <= state_next;
      match_reg <= count_en;
      done_reg  <= done_hit;
      err_reg   <= cfg_reject;
      if (cfg_accept) begin
        cfg_pattern_reg <= cfg_pattern_i;
        cfg_len_reg     <= cfg_len_i;
        cfg_overlap_reg <= cfg_overlap_i;
        cfg_target_reg  <= cfg_target_i;
      end
      if (start_ok) begin
        cnt_reg <= '0;
      end else if (count_en) begin
        cnt_reg <= cnt_inc;
      end
    end
  end

  assign busy_o      = (state_reg == ST_RUN);
  assign match_o     = match_reg;
  assign done_o      = done_reg;
  assign cfg_err_o   = err_reg;
  assign match_cnt_o = cnt_reg;

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
module tb_pattern_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic [7:0] cfg_target = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       d_valid = 1'b0;
  logic       d = 1'b0;

  logic       cfg_err, busy, match, done;
  logic [7:0] match_cnt;
  logic       sat_cfg_err, sat_busy, sat_match, sat_done;
  logic [1:0] sat_cnt;

  pattern_detect_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .cfg_we_i(cfg_we), .cfg_pattern_i(cfg_pattern),
    .cfg_len_i(cfg_len), .cfg_overlap_i(cfg_overlap), .cfg_target_i(cfg_target),
    .cfg_err_o(cfg_err), .start_i(start), .abort_i(abort), .d_valid_i(d_valid),
    .d_i(d), .busy_o(busy), .match_o(match), .match_cnt_o(match_cnt), .done_o(done)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation.
  pattern_detect_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) u_sat (
    .clk_i(clk), .rst_i(rst), .cfg_we_i(cfg_we), .cfg_pattern_i(cfg_pattern),
    .cfg_len_i(cfg_len), .cfg_overlap_i(cfg_overlap), .cfg_target_i(cfg_target[1:0]),
    .cfg_err_o(sat_cfg_err), .start_i(start), .abort_i(abort), .d_valid_i(d_valid),
    .d_i(d), .busy_o(sat_busy), .match_o(sat_match), .match_cnt_o(sat_cnt), .done_o(sat_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       m;
    logic       dn;
    logic       e;
    logic [7:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t ev;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_cnt = 0;

  // Monitor: any pulse on match/done/err must line up with the next queued event.
  always @(negedge clk) begin
    while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      ev = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_pulse: got nothing at cycle %0d, required match=%0b done=%0b err=%0b",
               ev.cyc, ev.m, ev.dn, ev.e);
    end
    if (match || done || cfg_err) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: got match=%0b done=%0b err=%0b cnt=%0d at cycle %0d, required none",
                 match, done, cfg_err, match_cnt, cyc);
      end else begin
        ev = exp_q.pop_front();
        if (ev.cyc != cyc || match != ev.m || done != ev.dn || cfg_err != ev.e ||
            (ev.m && match_cnt != ev.cnt)) begin
          n_bad++;
          $display("FAIL pulse: got cyc=%0d match=%0b done=%0b err=%0b cnt=%0d, required cyc=%0d match=%0b done=%0b err=%0b cnt=%0d",
                   cyc, match, done, cfg_err, match_cnt, ev.cyc, ev.m, ev.dn, ev.e, ev.cnt);
        end else begin
          $display("ok cyc=%0d match=%0b done=%0b err=%0b cnt=%0d", cyc, match, done, cfg_err, match_cnt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end else begin
      $display("ok %s = %0d", name, act);
    end
  endtask

  task automatic push(input logic m, input logic dn, input logic e, input int c);
    exp_q.push_back('{cyc + 1, m, dn, e, 8'(c)});
  endtask

  task automatic cfg_write(input logic [7:0] pat, input logic [3:0] len, input logic ov,
                           input logic [7:0] tgt, input logic exp_err, input logic with_start);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; cfg_target = tgt;
    start = with_start;
    if (with_start) exp_cnt = 0;
    if (exp_err) push(1'b0, 1'b0, 1'b1, 0);
    tick();
    cfg_we = 1'b0; start = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; exp_cnt = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  // bits[n-1] is sent first; mmask marks bits that complete a match.
  task automatic send_seq(input logic [31:0] bits, input int n, input logic [31:0] mmask,
                          input int done_idx);
    for (int i = 0; i < n; i++) begin
      d_valid = 1'b1;
      d = bits[n-1-i];
      if (mmask[n-1-i]) begin
        exp_cnt++;
        push(1'b1, (i == done_idx), 1'b0, exp_cnt);
      end
      tick();
    end
    d_valid = 1'b0; d = 1'b0;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_match", match, 0);
    chk("reset_done", done, 0);
    chk("reset_err", cfg_err, 0);
    chk("reset_cnt", match_cnt, 0);

    // 1: reset config 1011, overlapping
    do_start();
    chk("t1_busy_after_start", busy, 1);
    send_seq(32'b1011011, 7, 32'b0001001, -1);
    tick(); tick();
    chk("t1_cnt", match_cnt, 2);
    chk("t1_busy", busy, 1);
    do_abort();
    chk("t1_idle_after_abort", busy, 0);

    // 2: len 3 pattern 101, non-overlapping
    cfg_write(8'b101, 4'd3, 1'b0, 8'd0, 1'b0, 1'b0);
    do_start();
    send_seq(32'b10101, 5, 32'b00100, -1);
    tick();
    chk("t2_cnt", match_cnt, 1);
    do_abort();

    // 3: target 2, pattern 11; data during DONE is ignored
    cfg_write(8'b11, 4'd2, 1'b1, 8'd2, 1'b0, 1'b0);
    do_start();
    send_seq(32'b111, 3, 32'b011, 2);
    chk("t3_busy_in_done", busy, 0);
    d_valid = 1'b1; d = 1'b1;
    tick();
    d_valid = 1'b0;
    chk("t3_busy_after_done", busy, 0);
    tick();
    chk("t3_cnt_hold", match_cnt, 2);

    // 4: rejected lengths leave the reset config in place
    rst = 1'b1; tick(); rst = 1'b0;
    cfg_write(8'b11, 4'd0, 1'b1, 8'd0, 1'b1, 1'b0);
    cfg_write(8'b11, 4'd9, 1'b1, 8'd0, 1'b1, 1'b0);
    tick();
    do_start();
    cfg_write(8'b11, 4'd0, 1'b1, 8'd0, 1'b0, 1'b0);  // ignored in RUN, no error
    cfg_write(8'b11, 4'd2, 1'b1, 8'd1, 1'b0, 1'b0);  // ignored in RUN
    send_seq(32'b1011, 4, 32'b0001, -1);
    tick();
    chk("t4_cnt", match_cnt, 1);
    chk("t4_busy", busy, 1);

    // 5: abort with a completing bit suppresses the match
    do_abort();
    do_start();
    send_seq(32'b101101, 6, 32'b000100, -1);
    d_valid = 1'b1; d = 1'b1; abort = 1'b1;
    tick();
    d_valid = 1'b0; abort = 1'b0;
    chk("t5_idle_after_abort", busy, 0);
    chk("t5_cnt_hold", match_cnt, 1);
    tick();
    do_start();
    chk("t5_restart_cnt", match_cnt, 0);
    chk("t5_restart_busy", busy, 1);
    do_abort();
    // rejected write blocks a simultaneous start; accepted write applies first
    cfg_write(8'b101, 4'd0, 1'b1, 8'd1, 1'b1, 1'b1);
    chk("t5_start_blocked", busy, 0);
    cfg_write(8'b101, 4'd3, 1'b1, 8'd1, 1'b0, 1'b1);
    chk("t5_start_with_cfg", busy, 1);
    send_seq(32'b101, 3, 32'b001, 2);
    chk("t5_target1_done_busy", busy, 0);
    tick();

    // 6: reset mid-run, then saturation with reset config
    cfg_write(8'b11, 4'd2, 1'b1, 8'd0, 1'b0, 1'b0);
    do_start();
    send_seq(32'b11, 2, 32'b01, -1);
    rst = 1'b1; d_valid = 1'b1; d = 1'b1;
    tick();
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_match", match, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_err", cfg_err, 0);
    chk("t6_rst_cnt", match_cnt, 0);
    rst = 1'b0; d_valid = 1'b0;
    tick();
    d_valid = 1'b1; d = 1'b1;
    tick();
    d_valid = 1'b0;
    do_start();
    send_seq(32'b11011011011011011, 17, 32'b00001001001001001, -1);
    tick();
    chk("t6_cnt_wide", match_cnt, 5);
    chk("t6_cnt_saturated", sat_cnt, 3);
    do_abort();
    tick(); tick();
    chk("end_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
